// File: rtl/serial_adder_seq_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_seq_pkg;

   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/yAdder1.sv
// Combinational 1-bit full adder used as the serial adder's bit slice.
module yAdder1 (
   output logic z,
   output logic cOut,
   input  logic a,
   input  logic b,
   input  logic cin
);

   assign z    = a ^ b ^ cin;
   assign cOut = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_seq.sv
// Bit-serial adder: one operand bit pair per clock through yAdder1, with the
// carry held in a flip-flop between cycles and the sum shifted in LSB-first.
module serial_adder_seq
   import serial_adder_seq_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow
);

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state, state_d;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] a_sh, b_sh, s_sh, s_next;
   logic             carry, msb_cin;
   logic             z, c_out;
   logic             load, step, last;

   yAdder1 u_bit (
      .z    (z),
      .cOut (c_out),
      .a    (a_sh[0]),
      .b    (b_sh[0]),
      .cin  (carry)
   );

   // New sum bit enters at the MSB; written as a shift so WIDTH=1 needs no special case.
   assign s_next = (s_sh >> 1) | (WIDTH'(z) << (WIDTH - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // NOTE: every combinational output is given a default first so no path
   // through the case can leave it unassigned and infer a latch.
   always_comb begin
      state_d = state;
      load    = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (count == LAST) begin
               last    = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: the operand/sum shift registers are plain flops, not a memory, so
   // they are cleared by reset along with the result registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= '0;
         carry   <= 1'b0;
         a_sh    <= '0;
         b_sh    <= '0;
         s_sh    <= '0;
         sum     <= '0;
         cout    <= 1'b0;
         msb_cin <= 1'b0;
      end else if (load) begin
         a_sh  <= a;
         b_sh  <= b;
         carry <= cin;
         count <= '0;
      end else if (step) begin
         a_sh  <= a_sh >> 1;
         b_sh  <= b_sh >> 1;
         s_sh  <= s_next;
         carry <= c_out;
         if (last) begin
            sum     <= s_next;
            cout    <= c_out;
            msb_cin <= carry;
         end else begin
            count <= count + CW'(1);
         end
      end
   end

   assign busy     = (state == RUN);
   assign done     = (state == DONE);
   // Signed overflow: carry into the MSB differs from carry out of it.
   assign overflow = msb_cin ^ cout;

endmodule
